t5_preimage_search: RTL and testbench
=====================================

Name: t5_preimage_search

Overview:
- Inverse-direction companion to the 5-input/2-output benchmark function "t5".
- The forward block maps an input vector to outputs. This block takes a requested output pair and enumerates all 32 input vectors, one per cycle.
- It reports the lowest matching input vector and the total number of matching vectors.
- It sits beside the benchmark netlists as a sequential preimage finder and self-check engine.

Parameters:
- EARLY_EXIT, 0, 1 = stop scanning at the first match; 0 = always sweep all 32 vectors.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request.
- req_target  input  2  requested {po1,po0}.
- req_mask  input  2  per-bit compare enable; bit=0 means don't-care.
- resp_valid  output  1  result available.
- resp_ready  input  1  consumer accepts result.
- resp_found  output  1  at least one vector matched.
- resp_vec  output  5  lowest matching vector {pi4,pi3,pi2,pi1,pi0}; 0 if none.
- resp_count  output  6  number of matching vectors, 0..32.
- busy  output  1  high while in SCAN.

Behaviour:
- Evaluated function, with pi0 = vec[0] … pi4 = vec[4]:
  - po0 = (pi0 & pi2) | (pi1 & ~(pi2 & pi3))
  - po1 = ~(pi2 & pi3) & (pi1 | pi4)
- Match condition: (({po1,po0} ^ target) & mask) == 2'b00. Target and mask are captured at request acceptance.
- Reset (async assert, any state) forces:
  - state = IDLE, req_ready = 1, resp_valid = 0, busy = 0.
  - resp_found = 0, resp_vec = 0, resp_count = 0.
  - Internal vec counter = 0.
  - Reset mid-SCAN discards the scan; no response is produced.
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - req_ready = 1.
  - Accept on req_valid & req_ready at edge E0: capture target and mask, clear count/found/vec, counter = 0, go to SCAN.
- SCAN:
  - req_ready = 0, busy = 1.
  - Each cycle evaluates counter value v: vec 0 in cycle 1 after E0, vec 31 in cycle 32.
  - On a match: count += 1; if found was 0, set found = 1 and resp_vec = v.
  - EARLY_EXIT=0: after v = 31, go to DONE; resp_valid is high from cycle 33.
  - EARLY_EXIT=1: on the first match at v, go to DONE; resp_valid is high from cycle v+2, with count = 1.
  - Counter does not wrap. SCAN always leaves at v = 31 (resp_found = 0 and count = 0 if nothing matched).
- DONE:
  - resp_valid = 1; all resp_* held stable until resp_valid & resp_ready.
  - On that edge go to IDLE, resp_valid = 0. req_ready = 1 in the next cycle; no same-cycle accept.
  - resp_ready is ignored outside DONE.
- resp_count is 6 bits so the full value 32 (mask = 00) is representable without overflow.
- req_valid while not ready: ignored, not queued.
- Sum of counts over the four targets with mask = 11 is exactly 32.

Test Plan:
1. Reset, then target=00, mask=11, EARLY_EXIT=0 → resp_found=1, resp_vec=0, resp_count=9; resp_valid first high in cycle 33 after accept.
2. Full sweeps, mask=11:
   - target=01 ({po1,po0}: po0=1, po1=0) → vec=5, count=5.
   - target=10 → vec=16, count=5.
   - target=11 → vec=2, count=13.
3. mask=00, any target → found=1, vec=0, count=32, with no 6-bit overflow. mask=01, target=01 → vec=2, count=18.
4. EARLY_EXIT=1, target=10, mask=11 → resp_valid in cycle 18 after accept, vec=16, count=1. req_ready stays low during the scan; a req_valid pulse mid-scan is ignored.
5. Backpressure: hold resp_ready=0 for 10 cycles in DONE → outputs stable, req_ready=0; resp_ready=1 → IDLE next cycle, req_ready=1.
6. Assert rst at scan cycle 12 → immediately req_ready=1, resp_valid=0, busy=0, count=0. A new request after release completes normally with correct results.

Source files
------------

// File: rtl/t5_preimage_search.sv
// Preimage finder for the 5-input/2-output "t5" function: given a requested
// output pair (with per-bit don't-care mask) it walks all 32 input vectors,
// one per cycle, and reports the lowest matching vector and the match count.
// Ports: clk/rst (async active-high); req_valid/req_ready/req_target/req_mask
// request handshake; resp_valid/resp_ready/resp_found/resp_vec/resp_count
// result handshake; busy flags an active scan.
// Latency: 32 scan cycles (EARLY_EXIT=1: first match v + 1), result on the next.
// Backpressure: result held in DONE until resp_ready; requests refused until IDLE.
module t5_preimage_search #(
  parameter bit EARLY_EXIT = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_target,
  input  logic [1:0] req_mask,
  output logic       resp_valid,
  input  logic       resp_ready,
  output logic       resp_found,
  output logic [4:0] resp_vec,
  output logic [5:0] resp_count,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [4:0] vec;
  logic [1:0] target_q;
  logic [1:0] mask_q;
  logic       found_q;
  logic [4:0] vec_q;
  logic [5:0] count_q;
  logic       po0;
  logic       po1;
  logic       hit;
  logic       last;

  // Forward t5 evaluated on the current scan vector.
  always_comb begin
    po0  = (vec[0] & vec[2]) | (vec[1] & ~(vec[2] & vec[3]));
    po1  = ~(vec[2] & vec[3]) & (vec[1] | vec[4]);
    hit  = ((({po1, po0}) ^ target_q) & mask_q) == 2'b00;
    last = (vec == 5'd31);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = SCAN;
      // The counter never wraps: vector 31 always ends the sweep.
      SCAN:    if (last || (EARLY_EXIT && hit)) state_nxt = DONE;
      DONE:    if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec      <= 5'd0;
      target_q <= 2'b00;
      mask_q   <= 2'b00;
      found_q  <= 1'b0;
      vec_q    <= 5'd0;
      count_q  <= 6'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            target_q <= req_target;
            mask_q   <= req_mask;
            vec      <= 5'd0;
            found_q  <= 1'b0;
            vec_q    <= 5'd0;
            count_q  <= 6'd0;
          end
        end
        SCAN: begin
          if (hit) begin
            count_q <= count_q + 6'd1;
            // Scan is ascending, so the first hit is the lowest preimage.
            if (!found_q) begin
              found_q <= 1'b1;
              vec_q   <= vec;
            end
          end
          if (!last) vec <= vec + 5'd1;
        end
        default: ;
      endcase
    end
  end

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == DONE);
  assign busy       = (state == SCAN);
  assign resp_found = found_q;
  assign resp_vec   = vec_q;
  assign resp_count = count_q;

endmodule

// File: tb/tb_t5_preimage_search.sv
// Bench for t5_preimage_search: two instances (sweep-all and early-exit),
// directed requests with a scoreboard of expected results, latency,
// backpressure and mid-scan reset checks.
module tb_t5_preimage_search;

  typedef struct {
    bit       found;
    bit [4:0] vec;
    bit [5:0] count;
    int       lat;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       req_valid  [2];
  logic       req_ready  [2];
  logic [1:0] req_target [2];
  logic [1:0] req_mask   [2];
  logic       resp_valid [2];
  logic       resp_ready [2];
  logic       resp_found [2];
  logic [4:0] resp_vec   [2];
  logic [5:0] resp_count [2];
  logic       busy       [2];

  int   vectors;
  int   miscompares;
  exp_t sb[$];

  t5_preimage_search #(.EARLY_EXIT(1'b0)) u_full (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_target(req_target[0]), .req_mask(req_mask[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_found(resp_found[0]), .resp_vec(resp_vec[0]),
    .resp_count(resp_count[0]), .busy(busy[0])
  );

  t5_preimage_search #(.EARLY_EXIT(1'b1)) u_early (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_target(req_target[1]), .req_mask(req_mask[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_found(resp_found[1]), .resp_vec(resp_vec[1]),
    .resp_count(resp_count[1]), .busy(busy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: direct enumeration of the t5 truth table.
  function automatic exp_t model(input bit [1:0] tgt, input bit [1:0] msk, input bit ee);
    exp_t r;
    r.found = 1'b0; r.vec = 5'd0; r.count = 6'd0; r.lat = 33;
    for (int v = 0; v < 32; v++) begin
      bit a, b, c, d, e, o0, o1, m0, m1;
      a = v[0]; b = v[1]; c = v[2]; d = v[3]; e = v[4];
      o0 = (a && c) || (b && !(c && d));
      o1 = !(c && d) && (b || e);
      m0 = !msk[0] || (o0 == tgt[0]);
      m1 = !msk[1] || (o1 == tgt[1]);
      if (m0 && m1) begin
        if (!r.found) begin
          r.found = 1'b1;
          r.vec   = v[4:0];
        end
        r.count = r.count + 6'd1;
        if (ee) begin
          r.lat = v + 2;
          break;
        end
      end
    end
    return r;
  endfunction

  task automatic run_req(input int d, input bit [1:0] tgt, input bit [1:0] msk,
                         input int hold, input bit pulse, output int cnt);
    exp_t e;
    int   n;
    sb.push_back(model(tgt, msk, d == 1));
    @(negedge clk);
    chk("req_ready_idle", req_ready[d], 1);
    req_valid[d] = 1'b1; req_target[d] = tgt; req_mask[d] = msk;
    @(posedge clk);
    #1 req_valid[d] = 1'b0;
    n = 1;
    @(negedge clk);
    chk("busy_scan", busy[d], 1);
    chk("req_ready_scan", req_ready[d], 0);
    while (!resp_valid[d] && n < 40) begin
      if (pulse && n == 5) req_valid[d] = 1'b1;
      @(negedge clk);
      n++;
      if (pulse && n == 6) begin
        req_valid[d] = 1'b0;
        chk("req_ready_pulse", req_ready[d], 0);
        chk("busy_pulse", busy[d], 1);
      end
    end
    e = sb.pop_front();
    chk("latency", n, e.lat);
    chk("resp_found", resp_found[d], e.found);
    chk("resp_vec", resp_vec[d], e.vec);
    chk("resp_count", resp_count[d], e.count);
    cnt = resp_count[d];
    for (int h = 1; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", resp_valid[d], 1);
      chk("hold_req_ready", req_ready[d], 0);
      chk("hold_vec", resp_vec[d], e.vec);
      chk("hold_count", resp_count[d], e.count);
      chk("hold_found", resp_found[d], e.found);
    end
    resp_ready[d] = 1'b1;
    @(posedge clk);
    #1 resp_ready[d] = 1'b0;
    chk("idle_resp_valid", resp_valid[d], 0);
    chk("idle_req_ready", req_ready[d], 1);
  endtask

  initial begin
    int c, sum;
    vectors = 0; miscompares = 0;
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0; req_target[d] = 2'b00; req_mask[d] = 2'b00; resp_ready[d] = 1'b0;
    end
    #12;
    for (int d = 0; d < 2; d++) begin
      chk("rst_req_ready", req_ready[d], 1);
      chk("rst_resp_valid", resp_valid[d], 0);
      chk("rst_busy", busy[d], 0);
      chk("rst_found", resp_found[d], 0);
      chk("rst_vec", resp_vec[d], 0);
      chk("rst_count", resp_count[d], 0);
    end
    @(negedge clk); rst = 1'b0;

    // Full sweeps with exact mask; also the constants from the truth table.
    sum = 0;
    run_req(0, 2'b00, 2'b11, 1, 1'b0, c); sum += c; chk("count_t00", c, 9);
    run_req(0, 2'b01, 2'b11, 1, 1'b0, c); sum += c; chk("count_t01", c, 5);
    run_req(0, 2'b10, 2'b11, 1, 1'b0, c); sum += c; chk("count_t10", c, 5);
    run_req(0, 2'b11, 2'b11, 1, 1'b0, c); sum += c; chk("count_t11", c, 13);
    chk("count_sum", sum, 32);

    // Don't-care masks, including the full 32 count.
    run_req(0, 2'b10, 2'b00, 1, 1'b0, c); chk("count_all", c, 32);
    run_req(0, 2'b01, 2'b01, 1, 1'b0, c); chk("count_po0", c, 18);
    run_req(0, 2'b00, 2'b10, 1, 1'b0, c);

    // Early exit, with an ignored mid-scan request pulse.
    run_req(1, 2'b10, 2'b11, 1, 1'b1, c); chk("ee_count", c, 1);
    run_req(1, 2'b00, 2'b11, 1, 1'b0, c);
    run_req(1, 2'b11, 2'b11, 1, 1'b0, c);
    run_req(1, 2'b01, 2'b00, 1, 1'b0, c);

    // Backpressure: result held for 10 cycles.
    run_req(0, 2'b11, 2'b11, 10, 1'b0, c);
    run_req(1, 2'b01, 2'b11, 10, 1'b0, c);

    // Reset in scan cycle 12 discards the scan.
    @(negedge clk);
    req_valid[0] = 1'b1; req_target[0] = 2'b00; req_mask[0] = 2'b11;
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    repeat (12) @(negedge clk);
    chk("pre_rst_busy", busy[0], 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_req_ready", req_ready[0], 1);
    chk("mid_rst_resp_valid", resp_valid[0], 0);
    chk("mid_rst_busy", busy[0], 0);
    chk("mid_rst_count", resp_count[0], 0);
    chk("mid_rst_found", resp_found[0], 0);
    @(negedge clk); rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_rst_no_resp", resp_valid[0], 0);
    run_req(0, 2'b11, 2'b11, 1, 1'b0, c);
    run_req(0, 2'b01, 2'b11, 1, 1'b0, c);

    chk("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
